// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - Shared constants and state encoding for the tpu job sequencer.
package tpu_pkg;

  localparam int N_DEF     = 4;
  localparam int W_DEF     = 8;
  localparam int ACC_W_DEF = 20;
  localparam int AW_DEF    = 10;
  localparam int KW_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_FEED  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } seq_state_t;

endpackage

// File: rtl/tpu_job_sequencer_if.sv
// rtl/tpu_job_sequencer_if.sv - Command, operand SRAM, core and result bundle; SEQ_PERF_EN adds perf counters.
interface tpu_job_sequencer_if #(
  parameter int N     = tpu_pkg::N_DEF,
  parameter int W     = tpu_pkg::W_DEF,
  parameter int ACC_W = tpu_pkg::ACC_W_DEF,
  parameter int AW    = tpu_pkg::AW_DEF,
  parameter int KW    = tpu_pkg::KW_DEF
);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [KW-1:0]          cmd_k;
  logic [AW-1:0]          cmd_base;
  logic                   mem_rd_en;
  logic [AW-1:0]          mem_rd_addr;
  logic [N*W-1:0]         mem_rd_a;
  logic [N*W-1:0]         mem_rd_b;
  logic                   core_start;
  logic [KW-1:0]          core_cfg_k;
  logic                   core_in_valid;
  logic                   core_in_ready;
  logic [N*W-1:0]         core_a_vec_flat;
  logic [N*W-1:0]         core_b_vec_flat;
  logic                   core_busy;
  logic                   core_done;
  logic [N*N*ACC_W-1:0]   core_C_flat;
  logic                   res_valid;
  logic                   res_ready;
  logic [N*ACC_W-1:0]     res_row;
  logic                   res_last;
  logic                   busy;
  logic                   err;
`ifdef SEQ_PERF_EN
  logic [31:0]            perf_cycles;
  logic [31:0]            perf_stalls;
`endif

  modport master (
    input  cmd_valid, cmd_k, cmd_base,
    output cmd_ready,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_a, mem_rd_b,
    output core_start, core_cfg_k, core_in_valid, core_a_vec_flat, core_b_vec_flat,
    input  core_in_ready, core_busy, core_done, core_C_flat,
    output res_valid, res_row, res_last,
    input  res_ready,
    output busy, err
`ifdef SEQ_PERF_EN
    , output perf_cycles, perf_stalls
`endif
  );

  modport slave (
    output cmd_valid, cmd_k, cmd_base,
    input  cmd_ready,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_a, mem_rd_b,
    input  core_start, core_cfg_k, core_in_valid, core_a_vec_flat, core_b_vec_flat,
    output core_in_ready, core_busy, core_done, core_C_flat,
    input  res_valid, res_row, res_last,
    output res_ready,
    input  busy, err
`ifdef SEQ_PERF_EN
    , input perf_cycles, perf_stalls
`endif
  );

endinterface

// File: rtl/tpu_beat_fifo.sv
// rtl/tpu_beat_fifo.sv - Two-entry operand beat FIFO; head is visible on dout whenever count is non-zero.
module tpu_beat_fifo #(
  parameter int DW = 2 * tpu_pkg::N_DEF * tpu_pkg::W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tpu_job_sequencer.sv
// rtl/tpu_job_sequencer.sv - Sequences one matmul job: fetch K beats, feed tpu_core, capture C, drain rows.
// Optional SEQ_PERF_EN adds perf_cycles / perf_stalls counters.
module tpu_job_sequencer
  import tpu_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int AW    = AW_DEF,
  parameter int KW    = KW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  tpu_job_sequencer_if.master  bus
);

  localparam int BW  = N * W;
  localparam int RIW = N * ACC_W;
  localparam int RW  = (N > 1) ? $clog2(N) : 1;

  seq_state_t           state;
  logic [KW-1:0]        k_reg;
  logic [KW-1:0]        issued;
  logic [KW-1:0]        xfer;
  logic [AW-1:0]        rd_addr;
  logic                 inflight;
  logic                 err_reg;
  logic [RW-1:0]        row;
  logic [N*N*ACC_W-1:0] c_reg;
  logic [2*BW-1:0]      head;
  logic [1:0]           fifo_count;
  logic                 in_valid;
  logic                 pop;
  logic                 rd_en;
  logic [2:0]           occ_after;
  logic                 unused_status;

  assign unused_status = bus.core_busy;

  // Occupancy after this cycle's pop lets a read issue while the head drains,
  // which sustains one beat per cycle without ever exceeding two entries.
  assign in_valid  = (state == ST_FEED) && (fifo_count != 2'd0);
  assign pop       = in_valid && bus.core_in_ready;
  assign occ_after = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en     = (state == ST_FEED) && (issued < k_reg) && (occ_after < 3'd2);

  tpu_beat_fifo #(.DW(2 * BW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   ({bus.mem_rd_b, bus.mem_rd_a}),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      k_reg    <= '0;
      issued   <= '0;
      xfer     <= '0;
      rd_addr  <= '0;
      inflight <= 1'b0;
      err_reg  <= 1'b0;
      row      <= '0;
      c_reg    <= '0;
    end else begin
      inflight <= rd_en;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_k == '0) begin
              err_reg <= 1'b1;
            end else begin
              k_reg   <= bus.cmd_k;
              rd_addr <= bus.cmd_base;
              issued  <= '0;
              xfer    <= '0;
              err_reg <= 1'b0;
              state   <= ST_START;
            end
          end
        end
        ST_START: state <= ST_FEED;
        ST_FEED: begin
          if (rd_en) begin
            issued  <= issued + KW'(1);
            rd_addr <= rd_addr + AW'(1);
          end
          if (pop) begin
            xfer <= xfer + KW'(1);
            if (xfer == k_reg - KW'(1)) begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus.core_done) begin
            c_reg <= bus.core_C_flat;
            row   <= '0;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus.res_ready) begin
            if (row == RW'(N - 1)) begin
              row   <= '0;
              state <= ST_IDLE;
            end else begin
              row <= row + RW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready       = (state == ST_IDLE);
  assign bus.busy            = (state != ST_IDLE);
  assign bus.err             = err_reg;
  assign bus.core_start      = (state == ST_START);
  assign bus.core_cfg_k      = k_reg;
  assign bus.mem_rd_en       = rd_en;
  assign bus.mem_rd_addr     = rd_en ? rd_addr : '0;
  assign bus.core_in_valid   = in_valid;
  assign bus.core_a_vec_flat = in_valid ? head[BW-1:0] : '0;
  assign bus.core_b_vec_flat = in_valid ? head[2*BW-1:BW] : '0;
  assign bus.res_valid       = (state == ST_DRAIN);
  assign bus.res_last        = (state == ST_DRAIN) && (row == RW'(N - 1));
  assign bus.res_row         = (state == ST_DRAIN) ? c_reg[int'(row)*RIW +: RIW] : '0;

`ifdef SEQ_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stalls_q;

  // The accept cycle counts as the first cycle of the job.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if ((state == ST_IDLE) && bus.cmd_valid && (bus.cmd_k != '0)) begin
      perf_cycles_q <= 32'd1;
      perf_stalls_q <= '0;
    end else begin
      if ((state != ST_IDLE) && (perf_cycles_q != '1)) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if (in_valid && !bus.core_in_ready && (perf_stalls_q != '1)) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// tb/tb_tpu_job_sequencer.sv - Table-driven bench for tpu_job_sequencer with SRAM and core models.
module tb_tpu_job_sequencer;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int ACC_W = 20;
  localparam int AW    = 10;
  localparam int KW    = 16;
  localparam int CW    = N * N * ACC_W;

  typedef struct {
    int             k;
    int             base;
    int             stall_len;
    bit             res_toggle;
    logic [CW-1:0]  exp_c;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  tpu_job_sequencer_if #(.N(N), .W(W), .ACC_W(ACC_W), .AW(AW), .KW(KW)) bus ();

  tpu_job_sequencer #(.N(N), .W(W), .ACC_W(ACC_W), .AW(AW), .KW(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int                 a_mat [N][N];
  int                 b_mat [N][N];
  logic [2*N*W-1:0]   mem   [1024];
  logic [AW-1:0]      addr_log [$];
  int                 beat_cyc [$];
  logic [N*ACC_W-1:0] rows_q [$];
  bit                 last_q [$];
  int                 acc [N][N];
  int                 start_cnt = 0;
  int                 beat_cnt  = 0;
  int                 done_timer = 0;
  int                 cyc = 0;

  // Operand SRAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_a <= mem[bus.mem_rd_addr][N*W-1:0];
      bus.mem_rd_b <= mem[bus.mem_rd_addr][2*N*W-1:N*W];
      addr_log.push_back(bus.mem_rd_addr);
    end
  end

  // Core model: accumulates outer products; done is a level that drops on the next job's first beat.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      beat_cnt   = 0;
      done_timer = 0;
      bus.core_done <= 1'b0;
    end else begin
      if (bus.core_start) begin
        start_cnt++;
        beat_cnt   = 0;
        done_timer = 0;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) acc[i][j] = 0;
      end
      if (bus.core_in_valid && bus.core_in_ready) begin
        if (beat_cnt == 0) bus.core_done <= 1'b0;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            acc[i][j] += int'($signed(bus.core_a_vec_flat[i*W +: W])) *
                         int'($signed(bus.core_b_vec_flat[j*W +: W]));
        beat_cnt++;
        beat_cyc.push_back(cyc);
        if (beat_cnt == int'(bus.core_cfg_k)) done_timer = 3;
      end else if (done_timer > 0) begin
        done_timer--;
        if (done_timer == 0) begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              bus.core_C_flat[(i*N+j)*ACC_W +: ACC_W] <= ACC_W'(acc[i][j]);
          bus.core_done <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      rows_q.push_back(bus.res_row);
      last_q.push_back(bus.res_last);
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] pack_c(input int t[16]);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < N * N; i++) r[i*ACC_W +: ACC_W] = ACC_W'(t[i]);
    return r;
  endfunction

  task automatic load_mem(input int base);
    logic [2*N*W-1:0] w;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        w[i*W +: W]       = W'(a_mat[i][k]);
        w[N*W + i*W +: W] = W'(b_mat[k][i]);
      end
      mem[(base + k) % 1024] = w;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_mem_rd_en"}, bus.mem_rd_en, 0);
    chk({tag, "_mem_rd_addr"}, bus.mem_rd_addr, 0);
    chk({tag, "_core_start"}, bus.core_start, 0);
    chk({tag, "_core_cfg_k"}, bus.core_cfg_k, 0);
    chk({tag, "_core_in_valid"}, bus.core_in_valid, 0);
    chk({tag, "_core_a"}, bus.core_a_vec_flat, 0);
    chk({tag, "_core_b"}, bus.core_b_vec_flat, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_row"}, bus.res_row, 0);
    chk({tag, "_res_last"}, bus.res_last, 0);
    chk({tag, "_err"}, bus.err, 0);
  endtask

  task automatic run_job(input string tag, input vec_t v);
    int s0;
    int stall_left;
    int guard;
    load_mem(v.base);
    addr_log.delete();
    beat_cyc.delete();
    rows_q.delete();
    last_q.delete();
    s0 = start_cnt;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_k     = KW'(v.k);
    bus.cmd_base  = AW'(v.base);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk({tag, "_start_pulse"}, bus.core_start, 1);
    chk({tag, "_cfg_k"}, bus.core_cfg_k, v.k);
    chk({tag, "_err_clear"}, bus.err, 0);
    stall_left    = v.stall_len;
    bus.res_ready = 1'b1;
    guard         = 0;
    while (rows_q.size() < N && guard < 300) begin
      if (stall_left > 0 && start_cnt > s0 && beat_cnt == 2) begin
        bus.core_in_ready = 1'b0;
        stall_left--;
      end else begin
        bus.core_in_ready = 1'b1;
      end
      bus.res_ready = v.res_toggle ? ~bus.res_ready : 1'b1;
      @(negedge clk);
      guard++;
    end
    bus.core_in_ready = 1'b1;
    bus.res_ready     = 1'b1;
    chk({tag, "_no_timeout"}, guard < 300, 1);
    chk({tag, "_start_count"}, start_cnt - s0, 1);
    chk({tag, "_beats"}, beat_cyc.size(), v.k);
    chk({tag, "_reads"}, addr_log.size(), v.k);
    for (int i = 0; i < v.k && i < addr_log.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), addr_log[i], (v.base + i) % 1024);
    if (v.stall_len == 0 && beat_cyc.size() == v.k)
      chk({tag, "_back_to_back"}, beat_cyc[v.k-1] - beat_cyc[0], v.k - 1);
    for (int r = 0; r < N && r < rows_q.size(); r++) begin
      chk($sformatf("%s_row%0d", tag, r), rows_q[r], v.exp_c[r*N*ACC_W +: N*ACC_W]);
      chk($sformatf("%s_last%0d", tag, r), last_q[r], r == N - 1);
    end
    chk({tag, "_idle_busy"}, bus.busy, 0);
    chk({tag, "_idle_cmd_ready"}, bus.cmd_ready, 1);
`ifdef SEQ_PERF_EN
    chk({tag, "_perf_stalls"}, bus.perf_stalls, v.stall_len);
    if (!v.res_toggle)
      chk({tag, "_perf_cycles"}, bus.perf_cycles, v.k + 12 + v.stall_len);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs [6];
    int   t4 [16];
    int   t2 [16];
    int   t1 [16];
    int   s0;
    int   rd0;
    int   guard;

    a_mat = '{'{1, 2, 3, 4}, '{-1, 0, 1, 2}, '{5, 6, 7, 8}, '{0, 1, 0, 1}};
    b_mat = '{'{1, 0, 1, 0}, '{2, -1, 0, 1}, '{3, 1, 2, 1}, '{4, 0, -1, 2}};
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    t4 = '{30, 1, 3, 13,  10, 1, -1, 5,  70, 1, 11, 29,  6, -1, -1, 3};
    t2 = '{5, -2, 1, 2,  -1, 0, -1, 0,  17, -6, 5, 6,  2, -1, 0, 1};
    t1 = '{1, 0, 1, 0,  -1, 0, -1, 0,  5, 0, 5, 0,  0, 0, 0, 0};
    vecs[0] = '{k: 4, base: 0,    stall_len: 0, res_toggle: 1'b0, exp_c: pack_c(t4)};
    vecs[1] = '{k: 4, base: 0,    stall_len: 3, res_toggle: 1'b0, exp_c: pack_c(t4)};
    vecs[2] = '{k: 4, base: 1022, stall_len: 0, res_toggle: 1'b0, exp_c: pack_c(t4)};
    vecs[3] = '{k: 4, base: 0,    stall_len: 0, res_toggle: 1'b1, exp_c: pack_c(t4)};
    vecs[4] = '{k: 2, base: 100,  stall_len: 0, res_toggle: 1'b0, exp_c: pack_c(t2)};
    vecs[5] = '{k: 1, base: 1023, stall_len: 0, res_toggle: 1'b1, exp_c: pack_c(t1)};

    rst               = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_k         = '0;
    bus.cmd_base      = '0;
    bus.core_in_ready = 1'b1;
    bus.core_busy     = 1'b0;
    bus.res_ready     = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Zero-K command is rejected and flagged.
    rd0 = addr_log.size();
    s0  = start_cnt;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_k     = '0;
    bus.cmd_base  = AW'(5);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("zero_k_err", bus.err, 1);
    chk("zero_k_cmd_ready", bus.cmd_ready, 1);
    chk("zero_k_busy", bus.busy, 0);
    repeat (5) @(negedge clk);
    chk("zero_k_no_reads", addr_log.size() - rd0, 0);
    chk("zero_k_no_start", start_cnt - s0, 0);
    chk("zero_k_err_sticky", bus.err, 1);

    for (int v = 0; v < 6; v++) run_job($sformatf("job%0d", v), vecs[v]);

    // Reset while feeding: abort, then a fresh job must still complete.
    load_mem(0);
    s0 = start_cnt;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_k     = KW'(4);
    bus.cmd_base  = '0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    guard = 0;
    while (!(start_cnt > s0 && beat_cnt == 2) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("midrst_reached_beat2", guard < 50, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    rst = 1'b0;
    run_job("after_rst", vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_job_sequencer.md
Name: tpu_job_sequencer

Overview:
- Job-level controller in front of tpu_core: accepts one matmul command (K depth, operand base address), fetches K operand beats from a shared operand SRAM, drives the core's start/cfg_k/in_valid handshake, captures C on done and streams it out row by row.
- Sits between the host command interface / operand buffer and a single tpu_core instance. Replaces the hand-sequencing currently done in benches.

Parameters:
- N, 4, array dimension (rows = cols)
- W, 8, signed operand element width
- ACC_W, 20, signed accumulator element width
- AW, 10, operand SRAM address width
- KW, 16, width of K / cfg_k

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  job command valid
- cmd_ready  out  1  high only in IDLE
- cmd_k  in  KW  reduction depth K
- cmd_base  in  AW  SRAM address of beat 0
- mem_rd_en  out  1  SRAM read strobe
- mem_rd_addr  out  AW  read address
- mem_rd_a  in  N*W  A column for beat, element i at [i*W +: W]; valid 1 cycle after mem_rd_en
- mem_rd_b  in  N*W  B row for beat, same packing, same timing
- core_start  out  1  one-cycle start pulse
- core_cfg_k  out  KW  K held stable for whole job
- core_in_valid  out  1  operand beat valid
- core_in_ready  in  1  core accepts beat
- core_a_vec_flat  out  N*W  to core
- core_b_vec_flat  out  N*W  to core
- core_busy  in  1  core busy (status only)
- core_done  in  1  core result ready
- core_C_flat  in  N*N*ACC_W  C[i][j] at [(i*N+j)*ACC_W +: ACC_W]
- res_valid  out  1  result row valid
- res_ready  in  1  consumer ready
- res_row  out  N*ACC_W  C row r, C[r][j] at [j*ACC_W +: ACC_W]
- res_last  out  1  high with row N-1
- busy  out  1  not IDLE
- err  out  1  sticky: zero-K command rejected; cleared by next accepted command or rst

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. State IDLE, FIFO empty, counters 0. rst mid-job aborts immediately with no further beats; core shares rst.
- States: IDLE -> START -> FEED -> WAIT -> DRAIN -> IDLE.
- IDLE: cmd_valid&&cmd_ready accepts. cmd_k==0 -> set err, stay IDLE. Otherwise latch K/base, clear err, go START.
- START: core_start=1 for exactly one cycle, core_cfg_k=K. Next state FEED.
- FEED: read address = base+k, modulo 2^AW wrap. Issue mem_rd_en when (fifo_count+inflight)<2 and issued<K. Return data enters a 2-entry FIFO.
- FIFO head drives core_in_valid / a/b vectors. A beat transfers when core_in_valid && core_in_ready. Head is held stable while in_ready=0, and no beat is lost or duplicated.
- After the K-th transfer go WAIT; core_in_valid=0 and vectors are driven 0.
- Steady state with in_ready=1: one beat per cycle after 1-cycle fill latency.
- WAIT: on core_done (level or pulse), latch core_C_flat into a result register; go DRAIN. core_done seen in FEED is ignored.
- DRAIN: row r=0..N-1 presented on res_row with res_valid; r advances on res_valid&&res_ready. res_last=1 at r=N-1. Handshake on last row -> IDLE, busy=0.
- Values are passed bit-exact; no arithmetic on data.

Optional Feature:
- SEQ_PERF_EN defined: adds outputs perf_cycles[31:0] (cycles from command accept to last result handshake, inclusive) and perf_stalls[31:0] (FEED cycles with core_in_valid=1 && core_in_ready=0). Both clear on accept, hold after job, and saturate at all-ones.
- Undefined: ports and counters are absent.

Decomposition:
- Package tpu_pkg: state enum encodings and default N/W/ACC_W constants.
- One sub-module: tpu_beat_fifo, a 2-entry FIFO with push/pop/count, width 2*N*W.

Test Plan:
- Use A=[[1,2,3,4],[-1,0,1,2],[5,6,7,8],[0,1,0,1]] and B=[[1,0,1,0],[2,-1,0,1],[3,1,2,1],[4,0,-1,2]], K=4, base=0, in_ready and res_ready always 1 -> 4 beats on consecutive cycles, one start pulse, row0={30,1,3,13}, row1={10,1,-1,5}, res_last on row3.
- Same job with core_in_ready low 3 cycles mid-beat-2 -> beat order and values unchanged; perf_stalls=3 with SEQ_PERF_EN.
- cmd_k=0 -> err=1, no mem_rd_en, no core_start; next valid command clears err.
- base=2^AW-2, K=4 -> read addresses 1022,1023,0,1.
- res_ready toggled 0/1 every cycle -> each row held until accepted, 4 rows total.
- rst asserted during FEED at beat 2 -> next cycle: IDLE, cmd_ready=1, all other outputs 0; a fresh job then completes correctly.
